// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Moore-style control FSM for a multicycle RV32 subset datapath
//   (lw, sw, R-type, I-ALU, jal, beq). Datapath controls are decoded
//   combinationally from the state register. Two inputs also affect outputs:
//   mem_ready gates the fetch loads, and Zero gates the branch PC load. The
//   block also keeps a retired-instruction counter.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = reset)
//   op[6:0]    in   opcode field of the instruction register
//   Zero       in   ALU zero flag
//   mem_ready  in   memory access complete this cycle
//   PCWrite    out  PC load enable
//   AdrSrc     out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction/OldPC load enable
//   ResultSrc  out  result mux (00 ALUOut, 01 read data, 10 ALU result)
//   ALUSrcA    out  ALU A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB    out  ALU B select (00 rs2, 01 imm, 10 const 4)
//   ALUOp      out  00 add, 01 sub, 10 funct decode
//   ImmSrc     out  immediate format (00 I, 01 S, 10 B, 11 J)
//   RegWrite   out  register file write enable
//   retire     out  one-cycle pulse on instruction completion
//   illegal    out  one-cycle pulse on an unsupported opcode
//   instret    out  retired instruction count (wraps silently)
//   state      out  current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  // Raw strobes before reset gating
  logic pc_we, mem_we, ir_we, rf_we, retire_raw, illegal_raw;

  always_comb begin
    state_d     = state_q;
    pc_we       = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    retire_raw  = 1'b0;
    illegal_raw = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        rf_we      = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe is held across stalls; the store only retires on the
        // cycle the memory accepts it.
        AdrSrc     = 1'b1;
        mem_we     = 1'b1;
        retire_raw = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // jal retires later in ALUWB when the link register is written
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_we      = Zero;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format depends only on the opcode, independent of state
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // While reset is held the state reads FETCH, whose PCWrite/IRWrite follow
  // mem_ready; gating with reset keeps every strobe quiet during reset.
  assign PCWrite  = pc_we       & reset;
  assign MemWrite = mem_we      & reset;
  assign IRWrite  = ir_we       & reset;
  assign RegWrite = rf_we       & reset;
  assign retire   = retire_raw  & reset;
  assign illegal  = illegal_raw & reset;

  assign instret_d = instret_q + {31'd0, retire_raw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule
